// File: rtl/l1_l2_arbiter_pkg.sv
// Shared types for the L1 to L2 arbiter: port widths, FSM state and request command.
package l1_l2_arbiter_pkg;

  localparam int unsigned WordW = 16;
  localparam int unsigned LineW = 128;

  typedef logic [WordW-1:0] lc3b_word;
  typedef logic [LineW-1:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    arb_idle,
    arb_serve_i,
    arb_serve_d
  } lc3b_arb_state;

  typedef struct packed {
    logic read;
    logic write;
  } lc3b_mem_cmd;

endpackage

// File: rtl/l1_l2_arbiter_req_reg.sv
// Request registers that drive the L2 port: address, writeback data and command.
module arb_req_reg
  import l1_l2_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              clear_cmd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  lc3b_mem_cmd       cmd_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [LINE_W-1:0] wdata_o,
  output lc3b_mem_cmd       cmd_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  lc3b_mem_cmd       cmd_q;

  // Address and data hold after completion; only the command drops so L2 sees no new request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cmd_q   <= '0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      cmd_q   <= cmd_i;
    end else if (clear_cmd_i) begin
      cmd_q   <= '0;
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign cmd_o   = cmd_q;

endmodule

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter between the L1 I-cache and D-cache onto the shared L2 port.
module l1_l2_arbiter
  import l1_l2_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  lc3b_arb_state     state_q;
  logic              last_grant_q;  // 0 = I-cache, 1 = D-cache
  logic              i_req, d_req;
  logic              grant_i, grant_d;
  logic              load, clear_cmd;
  logic [ADDR_W-1:0] load_addr;
  lc3b_mem_cmd       load_cmd, cmd;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // On a tie the side that did not win last time is granted.
  assign grant_i = (state_q == arb_idle) & i_req & (~d_req | last_grant_q);
  assign grant_d = (state_q == arb_idle) & d_req & (~i_req | ~last_grant_q);

  assign load      = grant_i | grant_d;
  assign clear_cmd = (state_q != arb_idle) & l2_resp;
  assign load_addr = grant_i ? i_mem_address : d_mem_address;

  always_comb begin
    load_cmd = '0;
    if (grant_i) begin
      load_cmd.read = 1'b1;
    end else if (grant_d) begin
      load_cmd.write = d_mem_write;
      load_cmd.read  = ~d_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= arb_idle;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        arb_idle: begin
          if (grant_i) begin
            state_q      <= arb_serve_i;
            last_grant_q <= 1'b0;
          end else if (grant_d) begin
            state_q      <= arb_serve_d;
            last_grant_q <= 1'b1;
          end
        end
        arb_serve_i, arb_serve_d: begin
          if (l2_resp) state_q <= arb_idle;
        end
        default: state_q <= arb_idle;
      endcase
    end
  end

  arb_req_reg #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_req_reg (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (load),
    .clear_cmd_i (clear_cmd),
    .addr_i      (load_addr),
    .wdata_i     (d_mem_wdata),
    .cmd_i       (load_cmd),
    .addr_o      (l2_address),
    .wdata_o     (l2_wdata),
    .cmd_o       (cmd)
  );

  assign l2_read  = cmd.read;
  assign l2_write = cmd.write;

  assign i_mem_resp  = (state_q == arb_serve_i) & l2_resp;
  assign d_mem_resp  = (state_q == arb_serve_d) & l2_resp;
  assign i_mem_rdata = l2_rdata;
  assign d_mem_rdata = l2_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Randomized bench for l1_l2_arbiter against a transaction-level reference model.
module tb_l1_l2_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_mem_read = 1'b0;
  logic [15:0]  i_mem_address = '0;
  logic [127:0] i_mem_rdata;
  logic         i_mem_resp;
  logic         d_mem_read = 1'b0;
  logic         d_mem_write = 1'b0;
  logic [15:0]  d_mem_address = '0;
  logic [127:0] d_mem_wdata = '0;
  logic [127:0] d_mem_rdata;
  logic         d_mem_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata = '0;
  logic         l2_resp = 1'b0;

  l1_l2_arbiter #(
    .ADDR_W (16),
    .LINE_W (128)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_mem_read    (i_mem_read),
    .i_mem_address (i_mem_address),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_resp    (i_mem_resp),
    .d_mem_read    (d_mem_read),
    .d_mem_write   (d_mem_write),
    .d_mem_address (d_mem_address),
    .d_mem_wdata   (d_mem_wdata),
    .d_mem_rdata   (d_mem_rdata),
    .d_mem_resp    (d_mem_resp),
    .l2_read       (l2_read),
    .l2_write      (l2_write),
    .l2_address    (l2_address),
    .l2_wdata      (l2_wdata),
    .l2_rdata      (l2_rdata),
    .l2_resp       (l2_resp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: who owns L2 (0 none, 1 I, 2 D) and what request L2 should see.
  int           m_owner;
  int           m_last;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  logic         m_rd, m_wr;
  logic         i_done, d_done, was_reset;
  logic         i_want, d_want;
  int           n_i_grants, n_d_grants;

  initial begin
    m_owner = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_rd = 0; m_wr = 0;
    n_i_grants = 0; n_d_grants = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      i_done = 1'b0;
      d_done = 1'b0;
      i_want = i_mem_read;
      d_want = d_mem_read | d_mem_write;
      if (reset) begin
        m_owner = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_rd = 0; m_wr = 0;
      end else if (m_owner == 0) begin
        if (i_want && (!d_want || m_last == 1)) begin
          m_owner = 1; m_last = 0; m_addr = i_mem_address; m_rd = 1; m_wr = 0;
          n_i_grants++;
        end else if (d_want) begin
          m_owner = 2; m_last = 1; m_addr = d_mem_address; m_wdata = d_mem_wdata;
          m_wr = d_mem_write; m_rd = !d_mem_write;
          n_d_grants++;
        end
      end else if (l2_resp) begin
        if (m_owner == 1) i_done = 1'b1;
        else d_done = 1'b1;
        m_owner = 0; m_rd = 0; m_wr = 0;
      end
      was_reset = reset;

      #1;
      check_eq("l2_read", l2_read, m_rd);
      check_eq("l2_write", l2_write, m_wr);
      check_eq("l2_address", l2_address, m_addr);
      if (m_wr || was_reset) check_eq("l2_wdata", l2_wdata, m_wdata);

      // Next-cycle stimulus: caches hold requests until done, L2 answers at random.
      reset = (c < 2) || ($urandom_range(0, 79) == 0);
      if (i_done) i_mem_read = 1'b0;
      else if (!i_mem_read && $urandom_range(0, 2) == 0) begin
        i_mem_read    = 1'b1;
        i_mem_address = 16'($urandom_range(0, 65535));
      end
      if (d_done) begin
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
      end else if (!(d_mem_read || d_mem_write) && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin d_mem_read = 1'b1; d_mem_write = 1'b0; end
          1:       begin d_mem_read = 1'b0; d_mem_write = 1'b1; end
          default: begin d_mem_read = 1'b1; d_mem_write = 1'b1; end
        endcase
        d_mem_address = 16'($urandom_range(0, 65535));
        d_mem_wdata   = rand_line();
      end else if ($urandom_range(0, 3) == 0) begin
        d_mem_wdata = rand_line();
      end
      l2_rdata = rand_line();
      if (reset) l2_resp = 1'b0;
      else if (m_owner != 0) l2_resp = ($urandom_range(0, 3) == 0);
      else l2_resp = ($urandom_range(0, 7) == 0);

      #1;
      check_eq("i_mem_resp", i_mem_resp, (m_owner == 1) && l2_resp);
      check_eq("d_mem_resp", d_mem_resp, (m_owner == 2) && l2_resp);
      if (m_owner == 1 && l2_resp) check_eq("i_mem_rdata", i_mem_rdata, l2_rdata);
      if (m_owner == 2 && l2_resp) check_eq("d_mem_rdata", d_mem_rdata, d_mem_rdata === l2_rdata ? l2_rdata : l2_rdata);
    end
    check_eq("i_grants_seen", 128'(n_i_grants > 20), 128'(1));
    check_eq("d_grants_seen", 128'(n_d_grants > 20), 128'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
